// File: rtl/line_capture_sequencer.sv
// Line capture sequencer: after an arm request, waits for the next frame (vsync rising edge)
// and captures MAX_PIX pixel bytes from each of three selected lines into an external 16-bit
// SRAM, packing byte pairs into words. Each slot owns a MAX_PIX/2-word region starting at
// slot*(MAX_PIX/2).
//
// Ports:
//   ck, res                 clock, asynchronous active-high reset
//   arm                     one-cycle capture request (honoured only when idle)
//   vsync, href             frame sync / line valid, already synchronous to ck
//   pvalid, pdata           pixel byte strobe and data
//   sel_line0..2            line numbers to capture, in slot order
//   sram_addr, sram_dq      SRAM word address / write data ([7:0] = earlier byte)
//   ceb, web, bleb, bheb    active-low SRAM strobes
//   busy, done, err         status: not idle / end-of-capture pulse / sticky incomplete frame
//   line_cnt                current line number in the frame (first line = 1, saturates)
module line_capture_sequencer #(
  parameter int unsigned MAX_PIX = 64,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              ck,
  input  logic              res,
  input  logic              arm,
  input  logic              vsync,
  input  logic              href,
  input  logic              pvalid,
  input  logic [7:0]        pdata,
  input  logic [7:0]        sel_line0,
  input  logic [7:0]        sel_line1,
  input  logic [7:0]        sel_line2,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq,
  output logic              ceb,
  output logic              web,
  output logic              bleb,
  output logic              bheb,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        line_cnt
);

  typedef enum logic [2:0] {
    StIdle, StWaitVs, StWaitLine, StCapture, StFlush, StDone
  } state_e;

  localparam int unsigned HalfPix = MAX_PIX / 2;
  localparam logic [7:0]  MaxPix8 = 8'(MAX_PIX);

  state_e            state_q, state_d;
  logic              vs_q, hr_q;
  logic [7:0]        line_q, line_d;
  logic [1:0]        slot_q, slot_d;
  logic [7:0]        bcnt_q, bcnt_d;
  logic [7:0]        lat_q, lat_d;
  logic              pend_q, pend_d;    // even byte latched, not yet written
  logic              abort_q, abort_d;  // frame ended early: finish after this flush
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_q, dq_d;
  logic              wr_q, wr_d;        // write cycle this clock
  logic              hi_q, hi_d;        // high byte enabled in this write

  logic              vs_rise, hr_rise, hr_fall, accept;
  logic [7:0]        line_next, sel_cur;
  logic [ADDR_W-1:0] wr_addr;

  assign vs_rise   = vsync & ~vs_q;
  assign hr_rise   = href & ~hr_q;
  assign hr_fall   = ~href & hr_q;
  assign line_next = (line_q == 8'hFF) ? 8'hFF : line_q + 8'd1;
  assign accept    = pvalid & href & (bcnt_q < MaxPix8);
  // bcnt_q is odd for both a pair write and a pending partial, so >>1 is the word index
  assign wr_addr   = ADDR_W'(HalfPix * 32'(slot_q)) + ADDR_W'(bcnt_q[7:1]);

  always_comb begin
    case (slot_q)
      2'd0:    sel_cur = sel_line0;
      2'd1:    sel_cur = sel_line1;
      default: sel_cur = sel_line2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    slot_d  = slot_q;
    bcnt_d  = bcnt_q;
    lat_d   = lat_q;
    pend_d  = pend_q;
    abort_d = abort_q;
    err_d   = err_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    wr_d    = 1'b0;
    hi_d    = 1'b0;

    if (vs_rise) begin
      line_d = 8'd0;
    end else if (hr_rise) begin
      line_d = line_next;
    end

    case (state_q)
      StIdle: begin
        if (arm) begin
          err_d   = 1'b0;
          state_d = StWaitVs;
        end
      end
      StWaitVs: begin
        if (vs_rise) begin
          slot_d  = 2'd0;
          abort_d = 1'b0;
          state_d = StWaitLine;
        end
      end
      StWaitLine: begin
        if (vs_rise) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = StFlush;
        end else if (hr_rise && (line_next == sel_cur)) begin
          bcnt_d  = 8'd0;
          pend_d  = 1'b0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (accept) begin
          bcnt_d = bcnt_q + 8'd1;
          if (!bcnt_q[0]) begin
            lat_d  = pdata;
            pend_d = 1'b1;
          end else begin
            wr_d   = 1'b1;
            hi_d   = 1'b1;
            addr_d = wr_addr;
            dq_d   = {pdata, lat_q};
            pend_d = 1'b0;
          end
        end
        if (vs_rise) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = StFlush;
        end else if (hr_fall || (bcnt_d == MaxPix8)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (pend_q) begin
          wr_d   = 1'b1;
          addr_d = wr_addr;
          dq_d   = {8'h00, lat_q};
          pend_d = 1'b0;
        end
        if (abort_q || (slot_q == 2'd2)) begin
          state_d = StDone;
        end else begin
          slot_d  = slot_q + 2'd1;
          state_d = StWaitLine;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      state_q <= StIdle;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      line_q  <= 8'd0;
      slot_q  <= 2'd0;
      bcnt_q  <= 8'd0;
      lat_q   <= 8'd0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      dq_q    <= 16'd0;
      wr_q    <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
      hr_q    <= href;
      line_q  <= line_d;
      slot_q  <= slot_d;
      bcnt_q  <= bcnt_d;
      lat_q   <= lat_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
    end
  end

  assign sram_addr = addr_q;
  assign sram_dq   = dq_q;
  assign ceb       = ~wr_q;
  assign web       = ~wr_q;
  assign bleb      = ~wr_q;
  assign bheb      = ~(wr_q & hi_q);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign line_cnt  = line_q;

endmodule

// File: tb/tb_line_capture_sequencer.sv
// Bench for line_capture_sequencer: drives whole frames line by line and predicts the SRAM
// write list, done pulses and err flag from line-level rules (which line each slot selects,
// how many bytes it carries), then compares against writes observed on the SRAM strobes.
module tb_line_capture_sequencer;

  localparam int MaxPix = 64;
  localparam int Half   = MaxPix / 2;

  logic        ck, res, arm, vsync, href, pvalid;
  logic [7:0]  pdata, sel_line0, sel_line1, sel_line2;
  logic [7:0]  sram_addr;
  logic [15:0] sram_dq;
  logic        ceb, web, bleb, bheb, busy, done, err;
  logic [7:0]  line_cnt;

  line_capture_sequencer #(
    .MAX_PIX (MaxPix),
    .ADDR_W  (8)
  ) dut (
    .ck        (ck),
    .res       (res),
    .arm       (arm),
    .vsync     (vsync),
    .href      (href),
    .pvalid    (pvalid),
    .pdata     (pdata),
    .sel_line0 (sel_line0),
    .sel_line1 (sel_line1),
    .sel_line2 (sel_line2),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .ceb       (ceb),
    .web       (web),
    .bleb      (bleb),
    .bheb      (bheb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .line_cnt  (line_cnt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] dq;
    logic [1:0]  strb;   // {web, bleb}
    logic        hi_off; // bheb
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_chk, n_fail, done_cnt;

  // Reference model state
  int         m_state;  // 0 idle, 1 armed waiting for frame, 2 capturing
  int         mslot, mline, exp_done;
  logic       exp_err;
  logic [7:0] sel[3];

  always @(negedge ck) begin
    wr_t w;
    if (ceb === 1'b0) begin
      w.addr   = sram_addr;
      w.dq     = sram_dq;
      w.strb   = {web, bleb};
      w.hi_off = bheb;
      got_q.push_back(w);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic set_sel(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    sel_line0 = a; sel_line1 = b; sel_line2 = c;
    sel[0] = a; sel[1] = b; sel[2] = c;
  endtask

  task automatic do_arm;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    if (m_state == 0) begin
      m_state = 1;
      exp_err = 1'b0;
    end
  endtask

  task automatic frame_start;
    vsync = 1'b1;
    tick; tick;
    vsync = 1'b0;
    tick; tick;
    if (m_state == 1) begin
      m_state = 2;
      mslot   = 0;
    end else if (m_state == 2) begin
      exp_err  = 1'b1;
      exp_done++;
      m_state  = 0;
    end
    mline = 0;
  endtask

  // One line: href high for the bytes, then a 3-cycle gap (optionally with stray pvalid).
  task automatic send_line(input int nbytes, input bit noise);
    logic [7:0] b[$];
    bit hit;
    int n;
    wr_t w;
    if (mline < 255) mline++;
    hit = (m_state == 2) && (mline == int'(sel[mslot]));
    href = 1'b1; pvalid = 1'b0;
    tick;
    for (int i = 0; i < nbytes; i++) begin
      if (hit && $urandom_range(7) == 0) begin
        pvalid = 1'b0;
        tick;
      end
      pvalid = 1'b1;
      pdata  = 8'($urandom);
      b.push_back(pdata);
      tick;
    end
    href = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pvalid = noise;
      pdata  = 8'($urandom);
      tick;
    end
    pvalid = 1'b0;
    if (hit) begin
      n = (nbytes > MaxPix) ? MaxPix : nbytes;
      for (int i = 1; i < n; i += 2) begin
        w.addr = 8'(mslot * Half + i / 2); w.dq = {b[i], b[i-1]};
        w.strb = 2'b00; w.hi_off = 1'b0;
        exp_q.push_back(w);
      end
      if (n % 2 == 1) begin
        w.addr = 8'(mslot * Half + n / 2); w.dq = {8'h00, b[n-1]};
        w.strb = 2'b00; w.hi_off = 1'b1;
        exp_q.push_back(w);
      end
      mslot++;
      if (mslot == 3) begin
        m_state = 0;
        exp_done++;
      end
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, " write count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s write%0d {addr,dq,web,bleb,bheb}", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    chk({tag, " done pulses"}, done_cnt, exp_done);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] b0, b1;
    wr_t w;
    n_chk = 0; n_fail = 0; done_cnt = 0;
    m_state = 0; mslot = 0; mline = 0; exp_done = 0; exp_err = 1'b0;
    res = 1'b1; arm = 1'b0; vsync = 1'b0; href = 1'b0; pvalid = 1'b0; pdata = 8'h00;
    set_sel(8'h00, 8'h00, 8'h00);

    // Reset state
    #3;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset strobes", {ceb, web, bleb, bheb}, 4'b1111);
    chk("reset addr", sram_addr, 8'h00);
    chk("reset dq", sram_dq, 16'h0000);
    chk("reset line_cnt", line_cnt, 8'h00);
    tick;
    res = 1'b0;
    tick; tick;

    // Full frame: three 64-byte slots packed into words 0..95
    set_sel(8'h20, 8'h80, 8'hF0);
    do_arm;
    chk("armed busy", busy, 1'b1);
    frame_start;
    for (int l = 1; l <= 240; l++) send_line(200, 1'b0);
    tick; tick; tick;
    chk("full frame write count", got_q.size(), 96);
    if (got_q.size() == 96) chk("full frame last addr", got_q[95].addr, 8'd95);
    check_writes("full frame");
    check_status("full frame");
    chk("full frame line_cnt", line_cnt, 8'd240);

    // Short line (odd partial), over-long line (cut at MAX_PIX), empty line with stray pvalid
    set_sel(8'h20, 8'h21, 8'h22);
    do_arm;
    frame_start;
    for (int l = 1; l < 'h20; l++) send_line($urandom_range(3), 1'b1);
    send_line(5, 1'b1);
    send_line(MaxPix + 6, 1'b0);
    send_line(0, 1'b1);
    tick; tick; tick;
    chk("partial write count", got_q.size(), 3 + Half);
    if (got_q.size() >= 3) begin
      chk("partial addr", got_q[2].addr, 8'd2);
      chk("partial bheb", got_q[2].hi_off, 1'b1);
      chk("partial dq hi", 32'(got_q[2].dq[15:8]), 32'h0);
    end
    check_writes("partial");
    check_status("partial");

    // Descending selection: slot 1 never matches, next frame ends the capture with err
    set_sel(8'h20, 8'h10, 8'h30);
    do_arm;
    frame_start;
    for (int l = 1; l <= 'h40; l++) send_line((l == 'h20) ? 6 : $urandom_range(2), 1'b0);
    frame_start;
    tick; tick; tick;
    check_writes("descending");
    check_status("descending");
    chk("descending err set", err, 1'b1);

    // 300 lines: counter saturates, 0x2C is never reached through wrap
    set_sel(8'd10, 8'hFF, 8'h2C);
    do_arm;
    chk("arm clears err", err, 1'b0);
    frame_start;
    for (int l = 1; l <= 300; l++) send_line(2, 1'b0);
    chk("saturated line_cnt", line_cnt, 8'hFF);
    frame_start;
    tick; tick; tick;
    check_writes("saturate");
    check_status("saturate");

    // Extra arms while busy are ignored; reset mid-capture aborts without partial write
    set_sel(8'd2, 8'd5, 8'd7);
    do_arm;
    frame_start;
    arm = 1'b1; tick; arm = 1'b0; tick;
    arm = 1'b1; tick; arm = 1'b0; tick;
    chk("busy after extra arms", busy, 1'b1);
    send_line(0, 1'b0);
    href = 1'b1; tick;
    pvalid = 1'b1;
    b0 = 8'($urandom); pdata = b0; tick;
    b1 = 8'($urandom); pdata = b1; tick;
    pdata = 8'($urandom); tick;
    pvalid = 1'b0;
    #2;
    res = 1'b1;
    #1;
    chk("mid-capture reset strobes", {ceb, web, bleb, bheb}, 4'b1111);
    chk("mid-capture reset busy", busy, 1'b0);
    chk("mid-capture reset line_cnt", line_cnt, 8'h00);
    chk("mid-capture reset dq", sram_dq, 16'h0000);
    res = 1'b0;
    href = 1'b0;
    w.addr = 8'd0; w.dq = {b1, b0}; w.strb = 2'b00; w.hi_off = 1'b0;
    exp_q.push_back(w);
    m_state = 0; mline = 0;
    tick; tick; tick;
    check_writes("mid-capture reset");
    frame_start;
    for (int l = 1; l <= 8; l++) send_line(2, 1'b0);
    tick; tick;
    check_writes("after reset no arm");
    check_status("after reset no arm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
